// File: rtl/comparator_pkg.sv
// Shared definitions for the registered magnitude comparator: slice geometry
// and the (lt, eq, gt) result record.
package comparator_pkg;

    localparam int SLICE_W = 4;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_res_t;

    function automatic int num_slices(input int width);
        return (width + SLICE_W - 1) / SLICE_W;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// One slice of the compare tree: produces (lt, eq) for a W-bit field, with
// optional two's-complement ordering when it carries the operand sign bit.
module cmp_slice
    import comparator_pkg::*;
#(
    parameter int W = SLICE_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         is_msb_signed,
    output logic         lt_o,
    output logic         eq_o
);

    logic [W-1:0] a_m_s;
    logic [W-1:0] b_m_s;

    // Inverting both sign bits maps two's-complement order onto unsigned order
    always_comb begin
        a_m_s = a_i;
        b_m_s = b_i;
        if (is_msb_signed) begin
            a_m_s[W-1] = ~a_i[W-1];
            b_m_s[W-1] = ~b_i[W-1];
        end else begin
            a_m_s[W-1] = a_i[W-1];
            b_m_s[W-1] = b_i[W-1];
        end
        lt_o = (a_m_s < b_m_s);
        eq_o = (a_i == b_i);
    end

endmodule

// File: rtl/comparator.sv
// Registered N-bit magnitude comparator: sliced (lt, eq) core merged by a
// balanced tree, with Ls/Gr/Eq and out_valid registered one cycle later.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SIGNED_CMP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             Ls,
    output logic             Gr,
    output logic             Eq,
    output logic             out_valid
);

    localparam int NS = num_slices(WIDTH);
    localparam int LV = (NS > 1) ? $clog2(NS) : 0;
    localparam int NP = 1 << LV;
    localparam int EW = NS * SLICE_W;

    logic [EW-1:0] a_ext_s;
    logic [EW-1:0] b_ext_s;
    logic [NP-1:0] lt_leaf_s;
    logic [NP-1:0] eq_leaf_s;
    cmp_res_t      core_s;
    cmp_res_t      res_d;
    cmp_res_t      res_q;
    logic          valid_d;
    logic          valid_q;

    // Widen to whole slices; the top slice is sign-extended in signed mode
    always_comb begin
        if (SIGNED_CMP != 0) begin
            a_ext_s = EW'($signed(a));
            b_ext_s = EW'($signed(b));
        end else begin
            a_ext_s = EW'(a);
            b_ext_s = EW'(b);
        end
    end

    for (genvar i = 0; i < NP; i++) begin : g_slice
        if (i < NS) begin : g_cmp
            cmp_slice #(.W(SLICE_W)) u_slice (
                .a_i           (a_ext_s[i*SLICE_W +: SLICE_W]),
                .b_i           (b_ext_s[i*SLICE_W +: SLICE_W]),
                .is_msb_signed ((SIGNED_CMP != 0) && (i == NS - 1)),
                .lt_o          (lt_leaf_s[i]),
                .eq_o          (eq_leaf_s[i])
            );
        end else begin : g_pad
            // Neutral leaves pad the tree to a power of two
            assign lt_leaf_s[i] = 1'b0;
            assign eq_leaf_s[i] = 1'b1;
        end
    end

    // Balanced MSB-first merge: node k folds its upper half (k+s) over its lower half (k)
    always_comb begin
        logic [NP-1:0] lt_t;
        logic [NP-1:0] eq_t;
        lt_t = lt_leaf_s;
        eq_t = eq_leaf_s;
        for (int l = 0; l < LV; l++) begin
            for (int k = 0; k < NP; k += (2 << l)) begin
                lt_t[k] = lt_t[k + (1 << l)] | (eq_t[k + (1 << l)] & lt_t[k]);
                eq_t[k] = eq_t[k + (1 << l)] & eq_t[k];
            end
        end
        core_s.lt = lt_t[0];
        core_s.eq = eq_t[0];
        core_s.gt = ~lt_t[0] & ~eq_t[0];
    end

    // Load a fresh verdict only on a qualified sample, otherwise hold
    always_comb begin
        if (in_valid) begin
            res_d = core_s;
        end else begin
            res_d = res_q;
        end
        valid_d = in_valid;
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '{lt: 1'b0, eq: 1'b0, gt: 1'b0};
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign Ls        = res_q.lt;
    assign Gr        = res_q.gt;
    assign Eq        = res_q.eq;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: six instances (8/13/64 bits, unsigned and
// signed) share one random stream and are checked against an arithmetic model.
module tb_comparator;

    localparam int ND = 6;
    localparam int WS [ND] = '{8, 8, 13, 13, 64, 64};
    localparam int SS [ND] = '{0, 1, 0, 1, 0, 1};
    localparam logic [2:0] LS = 3'b100;
    localparam logic [2:0] GR = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [63:0]   a_s      = 64'd0;
    logic [63:0]   b_s      = 64'd0;
    logic [ND-1:0] ls_s;
    logic [ND-1:0] gr_s;
    logic [ND-1:0] eq_s;
    logic [ND-1:0] ov_s;

    logic [3*ND-1:0] sb_q [$];
    logic [3*ND-1:0] last_exp = '0;
    logic            exp_ov   = 1'b0;
    bit              seen     = 1'b0;
    int              n_checks = 0;
    int              n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        comparator #(.WIDTH(WS[g]), .SIGNED_CMP(SS[g])) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .a         (a_s[WS[g]-1:0]),
            .b         (b_s[WS[g]-1:0]),
            .Ls        (ls_s[g]),
            .Gr        (gr_s[g]),
            .Eq        (eq_s[g]),
            .out_valid (ov_s[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: reduce to the low w bits, read as signed or unsigned integer, compare
    function automatic logic [2:0] ref_flags(input logic [63:0] x, input logic [63:0] y,
                                             input int w, input bit sgn);
        logic [63:0] m, ux, uy;
        bit lt, eq;
        m  = (w == 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
        ux = x & m;
        uy = y & m;
        if (sgn) begin
            if (ux[w-1]) ux = ux | ~m;
            if (uy[w-1]) uy = uy | ~m;
            lt = $signed(ux) < $signed(uy);
        end else begin
            lt = ux < uy;
        end
        eq = (ux == uy);
        return lt ? LS : (eq ? EQ : GR);
    endfunction

    task automatic send(input logic v, input logic [63:0] x, input logic [63:0] y);
        logic [3*ND-1:0] e;
        in_valid = v;
        a_s      = x;
        b_s      = y;
        if (v) begin
            for (int g = 0; g < ND; g++) e[3*g +: 3] = ref_flags(x, y, WS[g], SS[g] != 0);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Directed check of the 8-bit instances against hand-derived constants
    task automatic dchk(input string name, input logic [2:0] eu, input logic [2:0] es,
                        input logic ov);
        @(negedge clk);
        #1;
        chk({name, "_u8"}, {ls_s[0], gr_s[0], eq_s[0]}, eu);
        chk({name, "_s8"}, {ls_s[1], gr_s[1], eq_s[1]}, es);
        chk({name, "_ov"}, ov_s[0], ov);
    endtask

    task automatic dcase(input string name, input logic [63:0] x, input logic [63:0] y,
                         input logic [2:0] eu, input logic [2:0] es);
        send(1'b1, x, y);
        dchk(name, eu, es, 1'b1);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 9))
            0:       return 64'd0;
            1:       return ~64'd0;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'h0000_0000_0000_1000;
            5:       return 64'h0000_0000_0000_0FFF;
            6:       return 64'h0000_0000_0000_0080;
            7:       return 64'h0000_0000_0000_007F;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Expected out_valid: in_valid delayed one edge, cleared by reset; reset drops pending samples
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ov   = 1'b0;
            last_exp = '0;
            seen     = 1'b0;
            sb_q.delete();
        end else begin
            exp_ov = in_valid;
        end
    end

    // Monitor: pop the scoreboard whenever a result is presented, otherwise expect a hold
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", ov_s, {ND{exp_ov}});
            if (ov_s[0]) begin
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    last_exp = sb_q.pop_front();
                    seen     = 1'b1;
                end
            end
            for (int g = 0; g < ND; g++) begin
                chk($sformatf("flags_w%0d_s%0d", WS[g], SS[g]),
                    {ls_s[g], gr_s[g], eq_s[g]}, last_exp[3*g +: 3]);
                if (seen) begin
                    chk($sformatf("onehot_w%0d_s%0d", WS[g], SS[g]),
                        64'($onehot({ls_s[g], gr_s[g], eq_s[g]})), 64'd1);
                end
            end
        end
    end

    initial begin
        #3;
        chk("reset_outputs", {ls_s, gr_s, eq_s, ov_s}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        dcase("lt_120_200", 64'd120, 64'd200, LS, GR);
        dcase("gt_150_100", 64'd150, 64'd100, GR, LS);
        dcase("eq_380_380", 64'd380, 64'd380, EQ, EQ);
        dcase("trunc_399_222", 64'd399, 64'd222, LS, LS);
        dcase("trunc_450_550", 64'd450, 64'd550, GR, LS);
        dcase("trunc_800_1000", 64'd800, 64'd1000, LS, GR);
        dcase("trunc_777_778", 64'd777, 64'd778, LS, LS);
        dcase("s_80_7f", 64'h80, 64'h7F, GR, LS);
        dcase("s_ff_00", 64'hFF, 64'h00, GR, LS);
        dcase("s_ff_fe", 64'hFF, 64'hFE, GR, GR);

        dcase("hold_load", 64'd630, 64'd630, EQ, EQ);
        send(1'b0, 64'd5, 64'd9);
        dchk("hold_idle", EQ, EQ, 1'b0);

        // Asynchronous reset between edges while Gr is showing
        dcase("pre_rst", 64'd20, 64'd10, GR, GR);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("async_rst_outputs", {ls_s, gr_s, eq_s, ov_s}, 64'd0);
        #1;
        rst_n = 1'b1;
        dcase("post_rst", 64'd3, 64'd200, LS, GR);

        for (int i = 0; i < 10000; i++) begin
            logic [63:0] x, y;
            x = pick();
            case ($urandom_range(0, 7))
                0:       y = x;
                1:       y = x ^ (64'd1 << $urandom_range(0, 63));
                default: y = pick();
            endcase
            send($urandom_range(0, 3) != 0, x, y);
        end

        send(1'b0, 64'd0, 64'd0);
        send(1'b0, 64'd0, 64'd0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/comparator.md
# comparator

Registered N-bit magnitude comparator. Compares operands `a` and `b` and drives three mutually exclusive flags: `Ls` (a < b), `Gr` (a > b) and `Eq` (a == b). Results are registered one cycle after a qualified input sample. It is a leaf datapath block used wherever a sorted or threshold decision is needed, such as min/max selection or limit checks.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits; legal range is 2 to 64.
- `SIGNED_CMP`, default 0: 0 compares unsigned operands; 1 compares two's-complement operands.

Ports:
- `clk`, input, 1 bit: the single clock. All state updates on its rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `in_valid`, input, 1 bit: qualifies `a` and `b` in the current cycle.
- `a`, input, WIDTH bits: operand A.
- `b`, input, WIDTH bits: operand B.
- `Ls`, output, 1 bit: registered flag, high when a < b.
- `Gr`, output, 1 bit: registered flag, high when a > b.
- `Eq`, output, 1 bit: registered flag, high when a == b.
- `out_valid`, output, 1 bit: high for one cycle when the flags reflect a new sample.

## Operation
- Only the low WIDTH bits of a driven value are significant. A testbench value of 399 on an 8-bit port is therefore compared as 143.
- Unsigned mode compares the operands by plain binary magnitude.
- Signed mode treats the MSB as the sign bit:
  - Differing sign bits: the operand with MSB = 1 is the lesser.
  - Equal sign bits: the unsigned comparison of the remaining bits decides.
- The compare core is purely combinational. It is built as a tree:
  - Split the operands into 4-bit slices, LSB-aligned. The top slice is zero-extended, or sign-handled in signed mode.
  - Each slice produces a (lt, eq) pair.
  - Pairs merge MSB-first: lt = lt_hi | (eq_hi & lt_lo), and eq = eq_hi & eq_lo.
  - gt is derived as ~lt & ~eq.
- At every clock edge where `in_valid` = 1, `Ls`, `Gr` and `Eq` load the core result and `out_valid` is set.
- When `in_valid` = 0, the flags hold their previous values and `out_valid` clears.
- Invariant: after the first accepted sample, exactly one of `Ls`, `Gr` and `Eq` is high at all times.

## Timing
- Latency is 1 cycle: a sample accepted at edge N appears on the outputs after edge N.
- Throughput is one sample per cycle. There is no back-pressure, and `in_valid` may be high continuously.
- Reset values: `Ls` = 0, `Gr` = 0, `Eq` = 0, `out_valid` = 0. This all-zero state is the only legal state in which no flag is set.
- Asserting `rst_n` mid-stream clears all outputs immediately, without waiting for a clock edge. Any sample on the input at that moment is discarded.
- On the first edge after `rst_n` deasserts, a sample with `in_valid` = 1 is accepted normally.
- Operands equal to 0 or to all-ones must produce the correct flags, including the signed boundaries between the most-negative and most-positive values.
- The combinational core must meet timing within one cycle for WIDTH up to 64.

## Structure
- Shared package `comparator_pkg`:
  - `SLICE_W` = 4.
  - A function returning the number of slices for a given width.
  - A typedef `cmp_res_t`, a struct holding the lt, eq and gt bits.
- Sub-module `cmp_slice`: a parameterised 4-bit (lt, eq) slice comparator. It has an `is_msb_signed` input that enables the sign-bit handling.
- The top level instantiates the slices with a generate loop, contains the merge tree, and holds the output registers.

## Test plan
- Basic unsigned cases (WIDTH = 8), each checked one cycle after `in_valid`:
  - a = 120, b = 200 gives Ls = 1.
  - a = 150, b = 100 gives Gr = 1.
  - a = 380, b = 380 (124 and 124 after truncation) gives Eq = 1.
- Truncation cases:
  - a = 399, b = 222 (143 vs 222) gives Ls = 1.
  - a = 450, b = 550 (194 vs 38) gives Gr = 1.
  - a = 800, b = 1000 (32 vs 232) gives Ls = 1.
  - a = 777, b = 778 (9 vs 10) gives Ls = 1.
- Signed mode (SIGNED_CMP = 1, WIDTH = 8):
  - a = 8'h80, b = 8'h7F gives Ls = 1.
  - a = 8'hFF, b = 8'h00 gives Ls = 1.
  - a = 8'hFF, b = 8'hFE gives Gr = 1.
- Hold behaviour: load a = b = 630 (Eq = 1), then drop `in_valid` and change the operands. `Eq` must stay 1 and `out_valid` must be 0.
- Asynchronous reset mid-stream: with Gr = 1 showing, pulse `rst_n` low between clock edges. All outputs must go to 0 immediately, and the next valid sample must be registered one cycle later.
- Randomised check at WIDTH = 13 and WIDTH = 64 over 10k samples:
  - The flags must be exactly one-hot.
  - The flags must match a behavioural model.
  - `out_valid` must track `in_valid` delayed by one cycle.
